ps2_scancode_rx: RTL and testbench
==================================

// Module: ps2_scancode_rx
// PURPOSE
//  Receives PS/2 keyboard frames and delivers one scan-code byte per frame to the VGA
//  display controller (keyboard/keyboard_en) and to the audio note selector.
//  Sits directly upstream of the display controller.
//  - Synchronises and glitch-filters the PS2_CLK/PS2_DAT pad inputs.
//  - Deserialises the 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
//  - Checks framing and parity, and aborts stalled frames on a timeout.
// PARAMETERS
//  FILTER_LEN      4      cycles PS2_CLK must be stable before a level change is accepted
//  TIMEOUT_CYCLES  50000  max cycles between filtered PS2_CLK falling edges inside a frame (1 ms @ 50 MHz)
// PORTS
//  CLOCK_50     in   1  50 MHz system clock
//  reset        in   1  synchronous, active-low reset
//  PS2_CLK      in   1  raw keyboard clock pad (asynchronous, idle high)
//  PS2_DAT      in   1  raw keyboard data pad (asynchronous, idle high)
//  keyboard     out  8  last valid scan-code byte; held until the next valid frame
//  keyboard_en  out  1  one-cycle strobe: keyboard was just updated
//  frame_err    out  1  one-cycle strobe: frame failed the parity or stop check
//  rx_busy      out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (reset==0 at a CLOCK_50 edge):
//   - state=IDLE; keyboard=8'h00; keyboard_en=0; frame_err=0; rx_busy=0.
//   - Shift register, bit counter, timeout counter and filter counter cleared.
//   - Filtered PS2_CLK and synchronised PS2_DAT preset to 1.
//   - Reset mid-frame discards the partial frame; no strobe is issued.
//  Input path:
//   - 2-flop synchroniser on each pad.
//   - clk_f (filtered clock) changes only after FILTER_LEN consecutive equal synchronised samples.
//   - fall = clk_f 1->0, one cycle wide. PS2_DAT is sampled on fall.
//  State machine:
//   - IDLE: on fall, if dat==0 -> DATA, bit_cnt=0. If dat==1 -> stay in IDLE, no error (noise).
//   - DATA: on each fall, shift dat into bit[bit_cnt] (LSB first), bit_cnt++.
//     After the 8th bit -> PARITY.
//   - PARITY: on fall, latch the parity bit -> STOP.
//   - STOP: on fall, evaluate the frame and go to IDLE.
//     - Valid when ^{data,parity}==1 and dat==1: keyboard<=data, and keyboard_en=1 in the next cycle.
//     - Otherwise: frame_err=1 in the next cycle, keyboard unchanged.
//  Latency: keyboard/keyboard_en are registered and valid exactly 1 cycle after the stop-bit fall.
//   keyboard and keyboard_en change in the same cycle.
//  Timeout:
//   - In DATA/PARITY/STOP, to_cnt increments each cycle and clears on fall.
//   - When to_cnt reaches TIMEOUT_CYCLES-1: -> IDLE, frame_err=1 for one cycle, keyboard unchanged.
//   - Counter width is $clog2(TIMEOUT_CYCLES); the counter never wraps.
//  Simultaneous events: fall in the same cycle as the timeout terminal count -> fall wins (counter clears).
//  Break/extended codes (F0, E0) are passed through as ordinary bytes. The downstream FSM
//   compares keyboard==8'hF0 as a level, so keyboard must stay stable between strobes.
//  keyboard_en and frame_err are never asserted in the same cycle.
// STRUCTURE
//  Shared include ps2_defs.vh:
//   - localparams PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_FRAME_BITS=11.
//   - FSM encodings IDLE/DATA/PARITY/STOP.
//  Sub-module ps2_input_sync: synchroniser + FILTER_LEN glitch filter + falling-edge detect.
//   Outputs clk_f, fall, dat_s.
//  Top level: FSM, shift register, bit counter, timeout counter, output registers.
// TESTING
//  1. Clean frame 8'h1C, odd parity, ~12.5 kHz PS2_CLK -> keyboard=8'h1C, keyboard_en high exactly 1 cycle, 1 cycle after the 11th fall.
//  2. Sequence 1C, F0, 1C -> three keyboard_en strobes; keyboard reads 1C, F0, 1C and holds between strobes.
//  3. Frame 8'h29 with the parity bit flipped -> frame_err 1 cycle, no keyboard_en, keyboard keeps previous value.
//  4. Stop bit driven 0 -> frame_err 1 cycle. Then a valid 8'h15 frame -> keyboard=8'h15.
//  5. Stall after 4 data bits for > TIMEOUT_CYCLES -> frame_err, rx_busy=0. Next frame 8'h1A received correctly.
//  6. 2-cycle PS2_CLK glitch (< FILTER_LEN) in IDLE -> no state change. Reset asserted mid-frame -> all outputs 0, no strobe.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared constants for the PS/2 scan-code receiver: frame layout, well-known
// scan-code prefixes, FSM encodings and the frame acceptance rule.
package ps2_scancode_rx_pkg;

   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam int         PS2_FRAME_BITS = 11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // Odd parity over data+parity and a high stop bit make a good frame.
   function automatic logic frame_ok(input logic [7:0] data,
                                     input logic       parity,
                                     input logic       stop);
      return (^{data, parity}) & stop;
   endfunction

endpackage

// File: rtl/ps2_scancode_rx_sync.sv
// Pad conditioning for the PS/2 port: two-flop synchronisers on clock and data,
// a FILTER_LEN-sample glitch filter on the clock and a one-cycle fall strobe.
module ps2_input_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic clk_f,
   output logic fall,
   output logic dat_s
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

   logic          clk_m;
   logic          clk_s;
   logic          dat_m;
   logic [FW-1:0] flt_cnt;

   // Two-flop synchronisers; both pads idle high out of reset.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         clk_m <= 1'b1;
         clk_s <= 1'b1;
         dat_m <= 1'b1;
         dat_s <= 1'b1;
      end else begin
         clk_m <= ps2_clk;
         clk_s <= clk_m;
         dat_m <= ps2_dat;
         dat_s <= dat_m;
      end
   end

   // Accept a new clock level only after FILTER_LEN consecutive differing samples;
   // fall is raised in the same cycle clk_f first reads low.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         clk_f   <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FLT_LAST) begin
            clk_f   <= clk_s;
            flt_cnt <= '0;
            fall    <= ~clk_s;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserialises start/8 data/odd parity/stop frames and
// presents one scan-code byte per good frame with a single-cycle strobe.
module ps2_scancode_rx
   import ps2_scancode_rx_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] keyboard,
   output logic       keyboard_en,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          clk_f;
   logic          fall;
   logic          dat_s;
   logic          edge_seen;
   logic [1:0]    state;
   logic [7:0]    shift;
   logic [2:0]    bit_cnt;
   logic          parity;
   logic [TW-1:0] to_cnt;

   ps2_input_sync #(
      .FILTER_LEN(FILTER_LEN)
   ) u_sync (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .ps2_clk (PS2_CLK),
      .ps2_dat (PS2_DAT),
      .clk_f   (clk_f),
      .fall    (fall),
      .dat_s   (dat_s)
   );

   // A data-sampling edge: the fall strobe while the filtered clock reads low.
   assign edge_seen = fall & ~clk_f;

   // Busy whenever a frame has started and not yet finished or timed out.
   assign rx_busy = (state != ST_IDLE);

   // Frame FSM, shift register, timeout counter and registered outputs.
   // A fall in the timeout terminal cycle is handled first, so it clears the counter.
   always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
         state       <= ST_IDLE;
         shift       <= '0;
         bit_cnt     <= '0;
         parity      <= 1'b0;
         to_cnt      <= '0;
         keyboard    <= '0;
         keyboard_en <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         keyboard_en <= 1'b0;
         frame_err   <= 1'b0;
         if (state == ST_IDLE) begin
            to_cnt <= '0;
            if (edge_seen && !dat_s) begin
               state   <= ST_DATA;
               bit_cnt <= '0;
            end
         end else if (edge_seen) begin
            to_cnt <= '0;
            case (state)
               ST_DATA: begin
                  shift[bit_cnt] <= dat_s;
                  bit_cnt        <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) begin
                     state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity <= dat_s;
                  state  <= ST_STOP;
               end
               default: begin
                  state <= ST_IDLE;
                  if (frame_ok(shift, parity, dat_s)) begin
                     keyboard    <= shift;
                     keyboard_en <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end else if (to_cnt == TO_LAST) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            frame_err <= 1'b1;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed frames, corrupted frames,
// timeout, glitch, reset mid-frame and a randomized frame run.
module tb_ps2_scancode_rx;
   import ps2_scancode_rx_pkg::*;

   localparam int FLT  = 4;
   localparam int TMO  = 200;
   localparam int HALF = 20;
   // pad edge -> 2 sync flops -> FLT filter samples -> 1 output register
   localparam int LAT  = 2 + FLT + 1;

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b0;
   logic       PS2_CLK  = 1'b1;
   logic       PS2_DAT  = 1'b1;
   logic [7:0] keyboard;
   logic       keyboard_en;
   logic       frame_err;
   logic       rx_busy;

   int         errors    = 0;
   int         checks    = 0;
   int         en_seen   = 0;
   int         err_seen  = 0;
   int         conflicts = 0;
   logic [7:0] exp_kb    = 8'h00;

   ps2_scancode_rx #(
      .FILTER_LEN    (FLT),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .PS2_CLK    (PS2_CLK),
      .PS2_DAT    (PS2_DAT),
      .keyboard   (keyboard),
      .keyboard_en(keyboard_en),
      .frame_err  (frame_err),
      .rx_busy    (rx_busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Tally strobes over the cycle that just ended.
   always @(posedge CLOCK_50) begin
      if (keyboard_en) en_seen++;
      if (frame_err) err_seen++;
      if (keyboard_en && frame_err) conflicts++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge CLOCK_50);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference rule: good when data+parity has an odd number of ones and stop is 1.
   function automatic bit model_valid(input logic [7:0] d, input logic p, input logic s);
      return (($countones({d, p}) % 2) == 1) && (s == 1'b1);
   endfunction

   // Drive the first nbits of a frame; on the 11th bit check the strobe timing.
   task automatic send_bits(input logic [7:0] d, input bit flip, input logic stopv, input int nbits);
      logic [10:0] f;
      bit          good;
      f[0]   = 1'b0;
      f[8:1] = d;
      f[9]   = ~(^d) ^ flip;
      f[10]  = stopv;
      good   = model_valid(d, f[9], stopv);
      for (int i = 0; i < nbits; i++) begin
         PS2_DAT = f[i];
         tick(HALF);
         PS2_CLK = 1'b0;
         if (i == PS2_FRAME_BITS - 1) begin
            for (int c = 1; c <= LAT + 1; c++) begin
               tick(1);
               if (c >= LAT - 1) begin
                  chk("lat_en",  32'(keyboard_en), 32'((c == LAT) && good));
                  chk("lat_err", 32'(frame_err),   32'((c == LAT) && !good));
               end
            end
            tick(HALF - (LAT + 1));
         end else begin
            tick(HALF);
         end
         PS2_CLK = 1'b1;
      end
      PS2_DAT = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input bit flip, input logic stopv);
      int e0;
      int r0;
      bit good;
      e0 = en_seen;
      r0 = err_seen;
      good = model_valid(d, ~(^d) ^ flip, stopv);
      send_bits(d, flip, stopv, PS2_FRAME_BITS);
      tick(HALF);
      if (good) exp_kb = d;
      chk({tag, "_kb"},   32'(keyboard), 32'(exp_kb));
      chk({tag, "_en"},   32'(en_seen - e0), 32'(good ? 1 : 0));
      chk({tag, "_err"},  32'(err_seen - r0), 32'(good ? 0 : 1));
      chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
   endtask

   initial begin
      int e0;
      int r0;
      logic [7:0] d;
      int kind;

      // Reset state
      reset = 1'b0;
      tick(3);
      chk("rst_kb",   32'(keyboard), 32'h00);
      chk("rst_en",   32'(keyboard_en), 32'd0);
      chk("rst_err",  32'(frame_err), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      reset = 1'b1;
      tick(5);

      // Clean frame, then make/break/make sequence with hold between strobes
      run_frame("f1c", 8'h1C, 1'b0, 1'b1);
      run_frame("s1c", 8'h1C, 1'b0, 1'b1);
      tick(30);
      chk("hold1c", 32'(keyboard), 32'h1C);
      run_frame("sf0", PS2_BREAK, 1'b0, 1'b1);
      tick(30);
      chk("holdf0", 32'(keyboard), 32'hF0);
      run_frame("s1c2", 8'h1C, 1'b0, 1'b1);
      run_frame("e0", PS2_EXT, 1'b0, 1'b1);

      // Parity error, stop error, then recovery
      run_frame("par29", 8'h29, 1'b1, 1'b1);
      run_frame("stop0", 8'h5A, 1'b0, 1'b0);
      run_frame("f15", 8'h15, 1'b0, 1'b1);

      // Stall after four data bits
      e0 = en_seen;
      r0 = err_seen;
      send_bits(8'h77, 1'b0, 1'b1, 5);
      tick(20);
      chk("stall_busy", 32'(rx_busy), 32'd1);
      tick(TMO + 20);
      chk("to_err",  32'(err_seen - r0), 32'd1);
      chk("to_en",   32'(en_seen - e0), 32'd0);
      chk("to_busy", 32'(rx_busy), 32'd0);
      chk("to_kb",   32'(keyboard), 32'(exp_kb));
      run_frame("f1a", 8'h1A, 1'b0, 1'b1);

      // Short clock glitch in idle, then a high-data clock pulse (noise)
      e0 = en_seen;
      r0 = err_seen;
      PS2_CLK = 1'b0;
      tick(2);
      PS2_CLK = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("glitch_busy", 32'(rx_busy), 32'd0);
      end
      PS2_DAT = 1'b1;
      PS2_CLK = 1'b0;
      tick(HALF);
      PS2_CLK = 1'b1;
      tick(HALF);
      chk("noise_busy", 32'(rx_busy), 32'd0);
      chk("noise_en",   32'(en_seen - e0), 32'd0);
      chk("noise_err",  32'(err_seen - r0), 32'd0);
      chk("noise_kb",   32'(keyboard), 32'(exp_kb));

      // Randomized frames: clean, bad parity or bad stop
      for (int n = 0; n < 20; n++) begin
         d    = 8'($urandom);
         kind = int'($urandom_range(0, 3));
         run_frame("rnd", d, kind == 0, (kind == 1) ? 1'b0 : 1'b1);
      end

      // Reset mid-frame
      send_bits(8'hA5, 1'b0, 1'b1, 6);
      e0 = en_seen;
      r0 = err_seen;
      reset = 1'b0;
      tick(2);
      chk("mr_kb",   32'(keyboard), 32'h00);
      chk("mr_en",   32'(keyboard_en), 32'd0);
      chk("mr_err",  32'(frame_err), 32'd0);
      chk("mr_busy", 32'(rx_busy), 32'd0);
      reset   = 1'b1;
      PS2_CLK = 1'b1;
      PS2_DAT = 1'b1;
      exp_kb  = 8'h00;
      tick(TMO + 50);
      chk("mr_nostrobe", 32'(en_seen - e0 + err_seen - r0), 32'd0);
      chk("mr_idle_kb",  32'(keyboard), 32'h00);
      run_frame("post", 8'h1C, 1'b0, 1'b1);

      chk("exclusive", 32'(conflicts), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
